// File: rtl/sccb_init_sequencer_if.sv
// Bus between the camera init sequencer and its surroundings: start/mirror/flip
// control, the init-table ROM port, the SCCB write handshake and status.
interface sccb_init_sequencer_if #(
  parameter int REG_AW = 8,
  parameter int REG_DW = 8,
  parameter int ROM_AW = 8
);
  logic                     start;
  logic                     mirror;
  logic                     flip;
  logic [ROM_AW-1:0]        rom_addr;
  logic [REG_AW+REG_DW-1:0] rom_data;
  logic                     wr_req;
  logic [REG_AW-1:0]        wr_addr;
  logic [REG_DW-1:0]        wr_data;
  logic                     wr_ack;
  logic                     wr_nack;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic [ROM_AW-1:0]        err_index;

  // Sequencer side
  modport master (
    input  start, mirror, flip, rom_data, wr_ack, wr_nack,
    output rom_addr, wr_req, wr_addr, wr_data, busy, done, error, err_index
  );

  // Environment side: ROM, SCCB master and capture control
  modport slave (
    output start, mirror, flip, rom_data, wr_ack, wr_nack,
    input  rom_addr, wr_req, wr_addr, wr_data, busy, done, error, err_index
  );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Camera register-init engine. Walks a synchronous init-table ROM and issues one
// SCCB register write per entry, with delay entries (address all ones), runtime
// mirror/flip patching of one register and bounded NACK retry.
module sccb_init_sequencer #(
  parameter int          REG_AW        = 8,
  parameter int          REG_DW        = 8,
  parameter int          ROM_AW        = 8,
  parameter int          TABLE_LEN     = 115,
  parameter int          POWERUP_TICKS = 20,
  parameter int          DELAY_TICKS   = 50,
  parameter logic [7:0]  MVFP_REG      = 8'h1e,
  parameter int          MAX_RETRY     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sccb_init_sequencer_if.master  bus
);

  // The shared tick counter serves both the power-up wait and delay entries, so it
  // must hold the larger of the two ranges; the delay product is never truncated.
  localparam int DLY_W   = REG_DW + $clog2(DELAY_TICKS + 1);
  localparam int PWR_W   = $clog2(POWERUP_TICKS + 1);
  localparam int CNT_W   = (DLY_W > PWR_W) ? DLY_W : PWR_W;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ROM_AW-1:0]  LAST_IDX  = ROM_AW'(TABLE_LEN - 1);
  localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(POWERUP_TICKS - 1);
  localparam logic [REG_AW-1:0]  MVFP_ADDR = REG_AW'(MVFP_REG);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, LATCH, WRITE, GAP, DELAY, DONE, ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   index_q, index_d;
  logic [CNT_W-1:0]    tick_q, tick_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                mirror_q, mirror_d;
  logic                flip_q, flip_d;
  logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [REG_DW-1:0]   wr_data_q, wr_data_d;
  logic [ROM_AW-1:0]   err_index_q, err_index_d;

  logic [REG_AW-1:0]   entryAddr;
  logic [REG_DW-1:0]   entryData;
  logic [REG_DW-1:0]   patchedData;
  logic [CNT_W-1:0]    delayProd;
  logic                doAdvance;

  assign entryAddr = bus.rom_data[REG_AW+REG_DW-1 -: REG_AW];
  assign entryData = bus.rom_data[REG_DW-1:0];
  assign delayProd = CNT_W'(entryData) * CNT_W'(DELAY_TICKS);

  // Overlay the latched mirror/flip bits onto the orientation register's data
  always_comb begin
    patchedData = entryData;
    if (entryAddr == MVFP_ADDR) begin
      patchedData[5] = mirror_q;
      patchedData[4] = flip_q;
    end
  end

  // State register and all datapath registers, cleared by the async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      index_q     <= '0;
      tick_q      <= '0;
      retry_q     <= '0;
      mirror_q    <= 1'b0;
      flip_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      tick_q      <= tick_d;
      retry_q     <= retry_d;
      mirror_q    <= mirror_d;
      flip_q      <= flip_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_index_q <= err_index_d;
    end
  end

  // Next-state logic: sequencing, table decode, retry policy and advance to next entry
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    tick_d      = tick_q;
    retry_d     = retry_q;
    mirror_d    = mirror_q;
    flip_d      = flip_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_index_d = err_index_q;
    doAdvance   = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.start) begin
          mirror_d    = bus.mirror;
          flip_d      = bus.flip;
          index_d     = '0;
          tick_d      = '0;
          retry_d     = '0;
          err_index_d = '0;
          state_d     = PWRUP;
        end
      end
      PWRUP: begin
        if (tick_q == PWR_LAST) begin
          tick_d  = '0;
          state_d = FETCH;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        if (&entryAddr) begin
          if (delayProd == '0) begin
            doAdvance = 1'b1;
          end else begin
            tick_d  = delayProd;
            state_d = DELAY;
          end
        end else begin
          wr_addr_d = entryAddr;
          wr_data_d = patchedData;
          retry_d   = '0;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (bus.wr_nack) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = GAP;
          end else begin
            err_index_d = index_q;
            state_d     = ERROR;
          end
        end else if (bus.wr_ack) begin
          retry_d   = '0;
          doAdvance = 1'b1;
        end
      end
      GAP: begin
        state_d = WRITE;
      end
      DELAY: begin
        if (tick_q <= CNT_W'(1)) begin
          tick_d    = '0;
          doAdvance = 1'b1;
        end else begin
          tick_d = tick_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (doAdvance) begin
      if (index_q == LAST_IDX) begin
        state_d = DONE;
      end else begin
        index_d = index_q + ROM_AW'(1);
        state_d = FETCH;
      end
    end
  end

  // Status and bus outputs are decoded straight from the registered state
  always_comb begin
    bus.rom_addr  = index_q;
    bus.wr_req    = (state_q == WRITE);
    bus.wr_addr   = wr_addr_q;
    bus.wr_data   = wr_data_q;
    bus.busy      = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    bus.done      = (state_q == DONE);
    bus.error     = (state_q == ERROR);
    bus.err_index = err_index_q;
  end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Generic camera register-init engine: walks an external synchronous init-table ROM and issues one register write per entry to the SCCB/I2C master via a req/ack handshake.
- Supersedes the fixed OV7670 table-only approach:
  - parametrised register address/data width (8-bit address OV7670, 16-bit address OV5640-class)
  - table length
  - delay entries
  - runtime mirror/flip patching
  - NACK retry
- Sits between the ROM table and the SCCB master in the camera_init path; signals done to the capture logic.

Parameters:
- REG_AW, 8, register address width in bits (8 or 16).
- REG_DW, 8, register data width in bits.
- ROM_AW, 8, ROM address width.
- TABLE_LEN, 115, number of valid entries (1..2**ROM_AW).
- POWERUP_TICKS, 20, clk cycles waited after start before the first fetch (minimum 1).
- DELAY_TICKS, 50, clk cycles per delay unit.
- MVFP_REG, 8'h1e, register whose data is patched with mirror/flip; zero-extended to REG_AW.
- MAX_RETRY, 3, NACK retries per entry before error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins sequence when not busy
- mirror  in  1  mirror request, sampled at accepted start
- flip  in  1  vertical flip request, sampled at accepted start
- rom_addr  out  ROM_AW  table index to ROM
- rom_data  in  REG_AW+REG_DW  {reg_addr, reg_data}, valid 1 cycle after rom_addr
- wr_req  out  1  write request to SCCB master
- wr_addr  out  REG_AW  register address
- wr_data  out  REG_DW  register data
- wr_ack  in  1  one-cycle pulse, write completed OK
- wr_nack  in  1  one-cycle pulse, write failed
- busy  out  1  high from accepted start until done/error
- done  out  1  level; all entries written
- error  out  1  level; retries exhausted
- err_index  out  ROM_AW  index of the failing entry

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, PWRUP, FETCH, LATCH, WRITE, GAP, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - clear done, error, err_index
  - latch mirror/flip
  - index=0, busy=1
  - go PWRUP
- start while busy: ignored.
- PWRUP: count POWERUP_TICKS cycles, then FETCH.
- FETCH: drive rom_addr=index for one cycle, then LATCH. rom_data is captured in LATCH (one-cycle ROM latency).
- LATCH: decode the entry.
  - Delay entry (reg_addr all ones): load delay counter with reg_data*DELAY_TICKS, go DELAY. No bus write.
    - reg_data=0 gives zero wait: next cycle advances.
  - reg_addr==MVFP_REG: wr_data = reg_data with bit5=mirror_latched, bit4=flip_latched; other bits unchanged.
  - Otherwise: wr_data = reg_data. wr_addr = reg_addr.
  - Non-delay entries go to WRITE with wr_req=1.
- WRITE:
  - wr_req, wr_addr and wr_data are held stable until wr_ack or wr_nack is seen.
  - wr_req drops the cycle after.
  - ack: retry count=0, advance.
  - nack: if retry count<MAX_RETRY, increment it and go GAP (one cycle, wr_req=0), then back to WRITE with the same data. Otherwise go ERROR with err_index=index.
  - ack and nack in the same cycle: treated as nack.
- Advance (after ack or delay expiry):
  - if index==TABLE_LEN-1: go DONE.
  - else index+1, go FETCH.
- DONE: done=1, busy=0, held until the next accepted start.
- ERROR: error=1, busy=0, held until the next accepted start.
- Width rules: delay product is computed at REG_DW+clog2(DELAY_TICKS+1) bits (no truncation). Index never wraps past TABLE_LEN-1.
- rst_n low mid-sequence: immediate return to reset values; any in-flight wr_req is dropped.
- wr_ack/wr_nack outside WRITE: ignored.

Test Plan:
- TABLE_LEN=3, entries {3a,04},{40,d0},{12,04}, ack 2 cycles after each req -> exactly 3 writes in order, done=1; busy low the same cycle done rises; rom_addr sequence 0,1,2.
- Entry {1e,31} with mirror=1, flip=0 -> wr_data=8'h21. With mirror=0, flip=1 -> 8'h11. With MVFP_REG=8'h1e and a 16-bit table ({001e,31}, REG_AW=16) -> patch also applied.
- Entry {ff,02}, DELAY_TICKS=50 -> no wr_req for 100 cycles (±FETCH/LATCH overhead of 2), then the next write.
- nack on entry 1 twice, then ack -> 3 wr_req pulses for entry 1, one idle cycle between each, then done. nack 4 times with MAX_RETRY=3 -> error=1, err_index=1, done=0.
- start pulsed while busy -> no effect; rst_n low during a WRITE of entry 2 -> wr_req=0 immediately; after release + start, sequence restarts from rom_addr=0.
- ack and nack together -> counted as nack. Spurious ack in IDLE -> no state change.
